uart_rx_periph: RTL
===================

// Module: uart_rx_periph
// PURPOSE
// - Memory-mapped UART receiver on the picorv32 data bus (clk_10MHz domain); the CPU-read direction of the serial link.
// - Deserialises 8N1 frames from the rx pin into a small FIFO.
// - Exposes status and data registers that the CPU reads and clears via bus writes.
// - The bus has no read strobe, so a byte is popped by writing a control bit, never by reading.
// PARAMETERS
// - CLK_FREQ_HZ   10_000_000   system clock frequency
// - BAUD          115_200      line rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD = 86 (integer division, truncated)
// - FIFO_DEPTH    8            receive FIFO entries, power of two, 2..16
// - BASE_ADDR     32'h00002010 word address of STATUS; RXDATA at BASE_ADDR+'hC
// PORTS
// - clk        in   1   system clock; the only clock
// - reset      in   1   synchronous, active-high reset
// - Address    in   32  CPU data address (DataAddress_o)
// - wr_i       in   1   CPU write enable (we_o)
// - entrada_i  in   32  CPU write data (DataOut_o)
// - salida_o   out  32  read data, combinational on Address
// - rx         in   1   asynchronous serial input, idle high
// - rx_irq     out  1   high while FIFO not empty
// BEHAVIOUR
// - Reset: FSM=IDLE, FIFO empty, overrun=0, frame_err=0, synchroniser flops=1, rx_irq=0, salida_o driven per map (STATUS reads 0).
// - rx passes a 2-flop synchroniser; all sampling uses the synchronised value.
// - Bit counter runs 0..CLKS_PER_BIT-1.
// - FSM:
//   - IDLE -> START on synchronised rx=0.
//   - START: wait CLKS_PER_BIT/2 (=43) cycles, then sample. 1 = false start -> IDLE. 0 -> DATA.
//   - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first -> STOP.
//   - STOP: after CLKS_PER_BIT cycles sample. 1 = push byte. 0 = set frame_err and discard byte. Both paths -> IDLE in the same cycle.
// - Push occurs in the stop-sample cycle; the byte is visible in STATUS/RXDATA on the next cycle.
// - FIFO full at push with no same-cycle pop: byte dropped, overrun set.
// - FIFO full at push with a same-cycle pop: both succeed, count unchanged.
// - Register map (reads; unmapped addresses read 32'h0):
//   - STATUS @BASE: [0] not_empty, [1] overrun, [2] frame_err, [3] full, [8:4] count, others 0.
//   - RXDATA @BASE+C: {24'h0, FIFO head}; reads 32'h0 when empty; a read has no side effects.
// - Writes, only when wr_i=1 && Address==BASE:
//   - entrada_i[0]=1 pops one entry; ignored when empty.
//   - entrada_i[1]=1 clears overrun.
//   - entrada_i[2]=1 clears frame_err.
//   - A set and a clear of the same flag in one cycle: set wins.
// - Writes to RXDATA or any other address are ignored.
// - Reset asserted mid-frame aborts the frame; no partial byte is pushed. Reception resumes on the next start bit after reset is released.
// - FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is held separately (0..FIFO_DEPTH).
// STRUCTURE
// - Package uart_rx_pkg holds:
//   - rx_state_t enum {IDLE, START, DATA, STOP};
//   - offsets STATUS_OFF='h0 and RXDATA_OFF='hC;
//   - status bit index constants.
// - Sub-module sync_fifo (parameterised WIDTH/DEPTH; push, pop, full, empty, count, head) instantiated once.
// - Top-level wiring change: the UART B mux entry at 32'h2020 or 32'h202C takes salida_o from this block, with BASE_ADDR=32'h2020.
// TESTING
// - Clocks are clk cycles at 10 MHz; the bench drives rx at exactly 86 clks/bit.
// 1. Frame 0x55 -> after stop: STATUS=32'h11, RXDATA=32'h55, rx_irq=1. Write 32'h1 to BASE -> STATUS=0, rx_irq=0.
// 2. Nine frames 0x01..0x09, no pops -> STATUS[3]=1, overrun=1, count=8. Eight pops read 0x01..0x08 in order. Write 32'h2 -> overrun=0.
// 3. Frame 0xA5 with stop bit 0 -> frame_err=1, count=0. Write 32'h4 -> STATUS=0.
// 4. rx low pulse of 20 cycles -> FSM back to IDLE, no push, no flags. A following 0x3C frame is received correctly.
// 5. Reset pulsed during DATA bit 4 -> FIFO empty, flags 0. The next frame 0xF0 is received correctly.
// 6. FIFO full, pop written in the exact stop-sample cycle -> count stays 8, overrun=0, new byte at tail.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and register-map constants for the memory-mapped UART receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam logic [31:0] STATUS_OFF = 32'h0000_0000;
  localparam logic [31:0] RXDATA_OFF = 32'h0000_000C;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_OVERRUN   = 1;
  localparam int ST_FRAME_ERR = 2;
  localparam int ST_FULL      = 3;
  localparam int ST_COUNT_LSB = 4;
  localparam int ST_COUNT_MSB = 8;

endpackage

// File: rtl/uart_rx_periph_fifo.sv
// Small synchronous FIFO; pointers wrap naturally, occupancy held in a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees a slot in the same cycle, so push into a full FIFO succeeds only alongside a pop.
  assign w_do_pop  = pop && (r_count != {CW{1'b0}});
  assign w_do_push = push && ((r_count != FULL_CNT) || w_do_pop);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == {CW{1'b0}});
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_periph.sv
// 8N1 UART receiver with an 8-entry FIFO, STATUS/RXDATA read registers and write-to-pop control.
module uart_rx_periph
  import uart_rx_pkg::*;
#(
  parameter int          CLK_FREQ_HZ = 10_000_000,
  parameter int          BAUD        = 115_200,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        wr_i,
  input  logic [31:0] entrada_i,
  output logic [31:0] salida_o,
  input  logic        rx,
  output logic        rx_irq
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int CW           = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             w_push;
  logic             w_ferr_set;
  logic             r_overrun;
  logic             r_frame_err;
  logic             w_wr_ctrl;
  logic             w_pop;
  logic             w_ovr_set;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [7:0]       w_head;
  logic [31:0]      w_status;
  logic             w_unused;

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
    end
  end

  // Next-state logic: half-bit wait to the start-bit centre, then whole-bit steps.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_ONE;
    w_bit_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = {CNT_W{1'b0}};
        if (!r_sync2) w_state_nxt = START;
        else          w_state_nxt = IDLE;
      end
      START: begin
        if (r_cnt == HALF_LAST) begin
          w_cnt_nxt = {CNT_W{1'b0}};
          w_bit_nxt = 3'd0;
          if (r_sync2) w_state_nxt = IDLE;
          else         w_state_nxt = DATA;
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          w_bit_nxt   = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = STOP;
          else                   w_state_nxt = DATA;
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (r_cnt == BIT_LAST) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_state_nxt = IDLE;
          if (r_sync2) w_push = 1'b1;
          else         w_ferr_set = 1'b1;
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign w_wr_ctrl = wr_i && (Address == BASE_ADDR + STATUS_OFF);
  assign w_pop     = w_wr_ctrl && entrada_i[0];
  assign w_ovr_set = w_push && w_full && !w_pop;
  assign w_unused  = &{1'b0, entrada_i[31:3]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_shift_nxt),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  // Sticky error flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovr_set)                     r_overrun <= 1'b1;
      else if (w_wr_ctrl && entrada_i[1]) r_overrun <= 1'b0;
      else                               r_overrun <= r_overrun;
      if (w_ferr_set)                    r_frame_err <= 1'b1;
      else if (w_wr_ctrl && entrada_i[2]) r_frame_err <= 1'b0;
      else                               r_frame_err <= r_frame_err;
    end
  end

  // Read mux; combinational on Address, reads have no side effects.
  always_comb begin
    w_status                             = 32'h0000_0000;
    w_status[ST_NOT_EMPTY]               = !w_empty;
    w_status[ST_OVERRUN]                 = r_overrun;
    w_status[ST_FRAME_ERR]               = r_frame_err;
    w_status[ST_FULL]                    = w_full;
    w_status[ST_COUNT_MSB:ST_COUNT_LSB]  = 5'(w_count);
    salida_o                             = 32'h0000_0000;
    if (Address == BASE_ADDR + STATUS_OFF) begin
      salida_o = w_status;
    end else if (Address == BASE_ADDR + RXDATA_OFF) begin
      if (w_empty) salida_o = 32'h0000_0000;
      else         salida_o = {24'h00_0000, w_head};
    end else begin
      salida_o = 32'h0000_0000;
    end
  end

  assign rx_irq = !w_empty;

endmodule
